// File: rtl/axi4_duth_noc_pkg.sv
// axi4_duth_noc_pkg: shared NoC flow-control types, VC receiver parameter struct and presets
package axi4_duth_noc_pkg;
  typedef enum logic {FLOW_CONTROL_CREDITS, FLOW_CONTROL_ELASTIC} flow_control_type;
  typedef struct packed {
    flow_control_type fc_type;
    logic [7:0]       buff_depth;
    logic [4:0]       num_vcs;
    logic             reg_cr_upd;
    logic             pop_check_valid;
  } link_fc_params_rcv_vc_type;
  localparam link_fc_params_rcv_vc_type RTR_VC2_CREDITS_3_FC_RCV = '{FLOW_CONTROL_CREDITS, 8'd3, 5'd2, 1'b1, 1'b1};
  localparam link_fc_params_rcv_vc_type NI_VC2_ELASTIC_2_FC_RCV  = '{FLOW_CONTROL_ELASTIC, 8'd2, 5'd2, 1'b0, 1'b1};
endpackage

// File: rtl/eb_one_slot.sv
// eb_one_slot: full-throughput single-slot elastic buffer (push_i/data_i/ready_o in, valid_o/data_o/pop_i out)
module eb_one_slot #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  input  logic         pop_i
);
  logic         full_q, full_d, do_push;
  logic [W-1:0] data_q, data_d;
  assign ready_o = ~full_q | pop_i;
  assign do_push = push_i & ready_o;
  assign valid_o = full_q;
  assign data_o  = data_q;
  always_comb begin
    full_d = do_push ? 1'b1 : (pop_i ? 1'b0 : full_q);
    data_d = do_push ? data_i : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) full_q <= 1'b0;
    else full_q <= full_d;
    data_q <= data_d;
  end
endmodule

// File: rtl/fifo_duth.sv
// fifo_duth: circular FIFO, registered head, push accepted when not full or popping (push_i/data_i/ready_o, valid_o/data_o/pop_i)
module fifo_duth #(
  parameter int W     = 16,
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  input  logic         pop_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;
  assign valid_o = cnt_q != '0;
  assign ready_o = cnt_q != CW'(DEPTH);
  assign data_o  = mem_q[rd_q];
  assign do_pop  = pop_i & valid_o;
  assign do_push = push_i & (ready_o | do_pop);
  always_comb begin
    rd_d  = do_pop ? ((rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
    wr_d  = do_push ? ((wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/flow_control_receiver_vc_buffer.sv
// rcv_vc_buffer: one VC buffer, depth 0 pass-through / 1 elastic slot / >1 FIFO (push_i/data_i/ready_o, valid_o/data_o/pop_i)
module rcv_vc_buffer #(
  parameter int W     = 16,
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  input  logic         pop_i
);
  if (DEPTH == 0) begin : g_pass
    assign ready_o = 1'b1;
    assign valid_o = push_i;
    assign data_o  = data_i;
  end else if (DEPTH == 1) begin : g_eb
    eb_one_slot #(.W(W)) u_eb (
      .clk(clk), .rst(rst), .push_i(push_i), .data_i(data_i), .ready_o(ready_o),
      .valid_o(valid_o), .data_o(data_o), .pop_i(pop_i)
    );
  end else begin : g_fifo
    fifo_duth #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push_i(push_i), .data_i(data_i), .ready_o(ready_o),
      .valid_o(valid_o), .data_o(data_o), .pop_i(pop_i)
    );
  end
endmodule

// File: rtl/flow_control_receiver_vc.sv
// flow_control_receiver_vc: VC link receiver; data_in/valid_in/vc_in demuxed to per-VC buffers -> data_out/valid_out/ready_in, back_notify credits or ready, sticky err_overflow/err_bad_vc
module flow_control_receiver_vc
  import axi4_duth_noc_pkg::*;
#(
  parameter int               LINK_WIDTH      = 16,
  parameter int               NUM_VCS         = 2,
  parameter int               BUFF_DEPTH      = 3,
  parameter flow_control_type FC_TYPE         = FLOW_CONTROL_CREDITS,
  parameter bit               REG_CR_UPD      = 1'b1,
  parameter bit               POP_CHECK_VALID = 1'b1,
  localparam int              VC_W            = NUM_VCS > 1 ? $clog2(NUM_VCS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LINK_WIDTH-1:0]         data_in,
  input  logic                          valid_in,
  input  logic [VC_W-1:0]               vc_in,
  output logic [NUM_VCS-1:0]            back_notify,
  output logic [NUM_VCS*LINK_WIDTH-1:0] data_out,
  output logic [NUM_VCS-1:0]            valid_out,
  input  logic [NUM_VCS-1:0]            ready_in,
  output logic                          err_overflow,
  output logic                          err_bad_vc
);
  localparam bit ELASTIC = FC_TYPE == FLOW_CONTROL_ELASTIC;
  logic [NUM_VCS-1:0] push, pop, ready, buf_ready, ovf, cr_q;
  logic               bad_vc, ovf_q, bad_q;
  assign bad_vc = valid_in & ({1'b0, vc_in} >= (VC_W + 1)'(NUM_VCS));
  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    assign push[v]  = valid_in & (vc_in == VC_W'(v)) & (~ELASTIC | ready[v]);
    assign pop[v]   = POP_CHECK_VALID ? valid_out[v] & ready_in[v] : ready_in[v];
    assign ready[v] = BUFF_DEPTH == 0 ? ready_in[v] : buf_ready[v];
    assign ovf[v]   = ~ELASTIC & push[v] & ~buf_ready[v] & ~pop[v];
    rcv_vc_buffer #(.W(LINK_WIDTH), .DEPTH(BUFF_DEPTH)) u_buf (
      .clk(clk), .rst(rst), .push_i(push[v]), .data_i(data_in), .ready_o(buf_ready[v]),
      .valid_o(valid_out[v]), .data_o(data_out[v*LINK_WIDTH +: LINK_WIDTH]), .pop_i(pop[v])
    );
  end
  assign back_notify  = ELASTIC ? ready : (REG_CR_UPD ? cr_q : pop);
  assign err_overflow = ovf_q;
  assign err_bad_vc   = bad_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cr_q  <= '0;
      ovf_q <= 1'b0;
      bad_q <= 1'b0;
    end else begin
      cr_q  <= pop;
      ovf_q <= ovf_q | (|ovf);
      bad_q <= bad_q | bad_vc;
    end
  end
endmodule

// File: tb/tb_flow_control_receiver_vc.sv
// tb_flow_control_receiver_vc: table, directed and queue-model random checks of flow_control_receiver_vc
module tb_flow_control_receiver_vc;
  import axi4_duth_noc_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic        a_rst = 1'b1, a_vld = 1'b0, a_vc = 1'b0, a_ovf, a_bad;
  logic [15:0] a_din = '0;
  logic [1:0]  a_rdy = '0, a_bn, a_vo;
  logic [31:0] a_dout;
  logic        b_rst = 1'b1, b_vld = 1'b0, b_vc = 1'b0, b_ovf, b_bad;
  logic [15:0] b_din = '0;
  logic [1:0]  b_rdy = '0, b_bn, b_vo;
  logic [31:0] b_dout;
  logic        c_rst = 1'b1, c_vld = 1'b0, c_ovf, c_bad;
  logic [1:0]  c_vc = '0;
  logic [15:0] c_din = '0;
  logic [2:0]  c_rdy = '0, c_bn, c_vo;
  logic [47:0] c_dout;
  flow_control_receiver_vc #(
    .LINK_WIDTH(16), .NUM_VCS(int'(RTR_VC2_CREDITS_3_FC_RCV.num_vcs)),
    .BUFF_DEPTH(int'(RTR_VC2_CREDITS_3_FC_RCV.buff_depth)), .FC_TYPE(RTR_VC2_CREDITS_3_FC_RCV.fc_type),
    .REG_CR_UPD(RTR_VC2_CREDITS_3_FC_RCV.reg_cr_upd), .POP_CHECK_VALID(RTR_VC2_CREDITS_3_FC_RCV.pop_check_valid)
  ) u_a (
    .clk(clk), .rst(a_rst), .data_in(a_din), .valid_in(a_vld), .vc_in(a_vc), .back_notify(a_bn),
    .data_out(a_dout), .valid_out(a_vo), .ready_in(a_rdy), .err_overflow(a_ovf), .err_bad_vc(a_bad)
  );
  flow_control_receiver_vc #(
    .LINK_WIDTH(16), .NUM_VCS(int'(NI_VC2_ELASTIC_2_FC_RCV.num_vcs)),
    .BUFF_DEPTH(int'(NI_VC2_ELASTIC_2_FC_RCV.buff_depth)), .FC_TYPE(NI_VC2_ELASTIC_2_FC_RCV.fc_type),
    .REG_CR_UPD(NI_VC2_ELASTIC_2_FC_RCV.reg_cr_upd), .POP_CHECK_VALID(NI_VC2_ELASTIC_2_FC_RCV.pop_check_valid)
  ) u_b (
    .clk(clk), .rst(b_rst), .data_in(b_din), .valid_in(b_vld), .vc_in(b_vc), .back_notify(b_bn),
    .data_out(b_dout), .valid_out(b_vo), .ready_in(b_rdy), .err_overflow(b_ovf), .err_bad_vc(b_bad)
  );
  flow_control_receiver_vc #(
    .LINK_WIDTH(16), .NUM_VCS(3), .BUFF_DEPTH(1), .FC_TYPE(FLOW_CONTROL_CREDITS),
    .REG_CR_UPD(1'b0), .POP_CHECK_VALID(1'b1)
  ) u_c (
    .clk(clk), .rst(c_rst), .data_in(c_din), .valid_in(c_vld), .vc_in(c_vc), .back_notify(c_bn),
    .data_out(c_dout), .valid_out(c_vo), .ready_in(c_rdy), .err_overflow(c_ovf), .err_bad_vc(c_bad)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic r, v, vc;
    logic [15:0] d;
    logic [1:0] rdy, evo, ebn;
    logic [15:0] ed0, ed1;
    logic eovf;
  } vec_t;
  vec_t tv[$];
  task automatic add(input logic r, v, vc, input logic [15:0] d, input logic [1:0] rdy, evo, ebn,
                     input logic [15:0] ed0, ed1, input logic eovf);
    vec_t t;
    t = '{r, v, vc, d, rdy, evo, ebn, ed0, ed1, eovf};
    tv.push_back(t);
  endtask

  logic [15:0] mq[2][$];
  logic [1:0]  m_cr;
  logic        m_ovf;
  int          cr_seen;
  task automatic a_step(input logic r, v, vc, input logic [15:0] d, input logic [1:0] rdy);
    logic [1:0] pp;
    a_rst = r; a_vld = v; a_vc = vc; a_din = d; a_rdy = rdy;
    for (int k = 0; k < 2; k++) pp[k] = mq[k].size() > 0 && rdy[k];
    if (r) begin
      mq[0].delete(); mq[1].delete(); m_cr = '0; m_ovf = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) if (pp[k]) void'(mq[k].pop_front());
      if (v) begin
        if (mq[vc].size() < 3) mq[vc].push_back(d);
        else m_ovf = 1'b1;
      end
      m_cr = pp;
    end
    @(posedge clk); #1;
    chk("model valid_out", a_vo, {mq[1].size() > 0, mq[0].size() > 0});
    chk("model back_notify", a_bn, m_cr);
    chk("model err_overflow", a_ovf, m_ovf);
    if (mq[0].size() > 0) chk("model head vc0", a_dout[15:0], mq[0][0]);
    if (mq[1].size() > 0) chk("model head vc1", a_dout[31:16], mq[1][0]);
    cr_seen += a_bn[0];
  endtask

  task automatic bc_step;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    add(1,0,0,16'h00,2'b00, 2'b00,2'b00,16'h00,16'h00,0);
    add(0,1,1,16'hA1,2'b00, 2'b10,2'b00,16'h00,16'hA1,0);
    add(0,1,1,16'hA2,2'b00, 2'b10,2'b00,16'h00,16'hA1,0);
    add(0,1,1,16'hA3,2'b00, 2'b10,2'b00,16'h00,16'hA1,0);
    add(0,0,0,16'h00,2'b10, 2'b10,2'b10,16'h00,16'hA2,0);
    add(0,0,0,16'h00,2'b10, 2'b10,2'b10,16'h00,16'hA3,0);
    add(0,0,0,16'h00,2'b10, 2'b00,2'b10,16'h00,16'h00,0);
    add(0,0,0,16'h00,2'b10, 2'b00,2'b00,16'h00,16'h00,0);
    add(0,1,0,16'hB0,2'b00, 2'b01,2'b00,16'hB0,16'h00,0);
    add(0,1,0,16'hB1,2'b00, 2'b01,2'b00,16'hB0,16'h00,0);
    add(0,1,0,16'hB2,2'b00, 2'b01,2'b00,16'hB0,16'h00,0);
    add(0,1,0,16'hBF,2'b00, 2'b01,2'b00,16'hB0,16'h00,1);
    add(0,1,0,16'hC0,2'b01, 2'b01,2'b01,16'hB1,16'h00,1);
    add(0,0,0,16'h00,2'b01, 2'b01,2'b01,16'hB2,16'h00,1);
    add(0,0,0,16'h00,2'b01, 2'b01,2'b01,16'hC0,16'h00,1);
    add(0,0,0,16'h00,2'b01, 2'b00,2'b01,16'h00,16'h00,1);
    add(0,0,0,16'h00,2'b00, 2'b00,2'b00,16'h00,16'h00,1);
    add(0,1,1,16'hD1,2'b00, 2'b10,2'b00,16'h00,16'hD1,1);
    add(0,1,1,16'hD2,2'b00, 2'b10,2'b00,16'h00,16'hD1,1);
    add(1,0,0,16'h00,2'b10, 2'b00,2'b00,16'h00,16'h00,0);
    add(0,0,0,16'h00,2'b10, 2'b00,2'b00,16'h00,16'h00,0);
    add(0,1,1,16'h55,2'b00, 2'b10,2'b00,16'h00,16'h55,0);
    add(0,0,0,16'h00,2'b10, 2'b00,2'b10,16'h00,16'h00,0);
    add(0,0,0,16'h00,2'b00, 2'b00,2'b00,16'h00,16'h00,0);
    foreach (tv[i]) begin
      a_rst = tv[i].r; a_vld = tv[i].v; a_vc = tv[i].vc; a_din = tv[i].d; a_rdy = tv[i].rdy;
      @(posedge clk); #1;
      chk($sformatf("tv%0d valid_out", i), a_vo, tv[i].evo);
      chk($sformatf("tv%0d back_notify", i), a_bn, tv[i].ebn);
      chk($sformatf("tv%0d err_overflow", i), a_ovf, tv[i].eovf);
      chk($sformatf("tv%0d err_bad_vc", i), a_bad, 0);
      if (tv[i].evo[0]) chk($sformatf("tv%0d data_out0", i), a_dout[15:0], tv[i].ed0);
      if (tv[i].evo[1]) chk($sformatf("tv%0d data_out1", i), a_dout[31:16], tv[i].ed1);
    end

    a_step(1, 0, 0, 16'h0, 2'b00);
    begin
      int sent = 0;
      logic [15:0] exp_next = 16'h0;
      logic [1:0] rdy;
      cr_seen = 0;
      for (int c = 0; c < 40; c++) begin
        rdy = (c % 2 == 0) ? 2'b01 : 2'b00;
        if (a_vo[0] && rdy[0]) begin
          chk("wrap order", a_dout[15:0], exp_next);
          exp_next++;
        end
        if (sent < 10 && mq[0].size() < 3) begin
          a_step(0, 1, 0, 16'(sent), rdy);
          sent++;
        end else a_step(0, 0, 0, 16'h0, rdy);
      end
      chk("wrap flits out", exp_next, 10);
      chk("wrap credits", cr_seen, 10);
    end

    a_step(1, 0, 0, 16'h0, 2'b00);
    for (int c = 0; c < 400; c++)
      a_step($urandom_range(0, 99) == 0, 1'($urandom), 1'($urandom), 16'($urandom), 2'($urandom));

    b_rst = 1'b1; bc_step();
    chk("el reset bn", b_bn, 2'b11);
    chk("el reset vo", b_vo, 2'b00);
    b_rst = 1'b0; b_vld = 1'b1; b_vc = 1'b0; b_din = 16'hE0; bc_step();
    chk("el one bn", b_bn, 2'b11);
    chk("el one vo", b_vo, 2'b01);
    b_din = 16'hE1; bc_step();
    chk("el full bn", b_bn, 2'b10);
    b_din = 16'hE2; bc_step();
    chk("el blocked bn", b_bn, 2'b10);
    chk("el blocked head", b_dout[15:0], 16'hE0);
    b_vc = 1'b1; b_din = 16'hF0; bc_step();
    chk("el vc1 vo", b_vo, 2'b11);
    chk("el vc1 data", b_dout[31:16], 16'hF0);
    chk("el vc1 bn", b_bn, 2'b10);
    b_vld = 1'b0; b_rdy = 2'b01; bc_step();
    chk("el pop head", b_dout[15:0], 16'hE1);
    chk("el pop bn", b_bn, 2'b11);
    bc_step();
    chk("el drained vo", b_vo, 2'b10);
    chk("el errors", {b_ovf, b_bad}, 2'b00);

    c_rst = 1'b1; bc_step();
    chk("bad reset vo", c_vo, 3'b000);
    chk("bad reset flag", c_bad, 1'b0);
    c_rst = 1'b0; c_vld = 1'b1; c_vc = 2'd3; c_din = 16'h77; bc_step();
    chk("bad flag", c_bad, 1'b1);
    chk("bad vo", c_vo, 3'b000);
    c_vld = 1'b0; c_rdy = 3'b111; bc_step();
    chk("bad no credit", c_bn, 3'b000);
    chk("bad sticky", c_bad, 1'b1);
    c_rdy = 3'b000; c_vld = 1'b1; c_vc = 2'd2; c_din = 16'hE0; bc_step();
    chk("d1 vo", c_vo, 3'b100);
    chk("d1 data", c_dout[47:32], 16'hE0);
    c_din = 16'hE1; c_rdy = 3'b100; #1;
    chk("d1 comb credit", c_bn, 3'b100);
    bc_step();
    chk("d1 pass data", c_dout[47:32], 16'hE1);
    chk("d1 pass ovf", c_ovf, 1'b0);
    c_din = 16'hE2; c_rdy = 3'b000; bc_step();
    chk("d1 overflow", c_ovf, 1'b1);
    chk("d1 kept data", c_dout[47:32], 16'hE1);
    c_vld = 1'b0; c_rdy = 3'b100; bc_step();
    chk("d1 drop vo", c_vo, 3'b000);
    chk("d1 drop bn", c_bn, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/flow_control_receiver_vc.md
Name: flow_control_receiver_vc

Overview:
Link-side receiver for a virtual-channel (VC) link.
- The sender tags each incoming flit with a VC index.
- The block demultiplexes each flit into a per-VC buffer and presents one output channel per VC.
- It returns per-VC back-notification: a credit pulse in credit-based mode, a ready level in elastic mode.
- It sits at router/NI input ports, after the link and before VC allocation or arbitration. It also flags protocol violations: overflow and illegal VC index.

Parameters:
LINK_WIDTH, 16, flit width in bits.
NUM_VCS, 2, number of virtual channels (1..16).
BUFF_DEPTH, 3, slots per VC. 0 = no buffer (pass-through); 1 = single-slot elastic buffer; >1 = circular FIFO.
FC_TYPE, FLOW_CONTROL_CREDITS, link protocol: FLOW_CONTROL_CREDITS or FLOW_CONTROL_ELASTIC.
REG_CR_UPD, 1, credit mode only: credit pulses are registered one cycle before driving back_notify.
POP_CHECK_VALID, 1, a pop is issued only when the VC buffer holds data.

Ports:
clk  in  1  clock; all logic is on rising edge.
rst  in  1  synchronous, active-high reset.
data_in  in  LINK_WIDTH  incoming flit.
valid_in  in  1  flit valid.
vc_in  in  VC_W  VC index of the flit; VC_W = max(1, clog2(NUM_VCS)).
back_notify  out  NUM_VCS  per-VC credit pulse (credit mode) or per-VC ready (elastic mode).
data_out  out  NUM_VCS*LINK_WIDTH  per-VC head flit; VC v occupies bits [v*LINK_WIDTH +: LINK_WIDTH].
valid_out  out  NUM_VCS  per-VC head valid.
ready_in  in  NUM_VCS  per-VC downstream ready.
err_overflow  out  1  sticky: a flit arrived for a full VC.
err_bad_vc  out  1  sticky: a flit arrived with vc_in >= NUM_VCS.

Behaviour:
Reset (synchronous, rst high at a rising edge):
- All VC buffers are emptied.
- valid_out = 0, back_notify = 0 in credit mode, error flags = 0, registered credits are cleared.
- A reset mid-stream discards all buffered flits; no credits are returned for discarded flits.
- In elastic mode back_notify is combinational from occupancy, so it reads all-ones (all buffers empty) once reset is applied.

Demux and push:
- push[v] = valid_in & (vc_in == v).
- Elastic mode: the push is further qualified by ready[v].
- Credit mode: the push is unconditional; the sender's credit counter is trusted.

Per-VC buffer, BUFF_DEPTH >= 2:
- Circular FIFO with read pointer, write pointer and count, each wrapping at BUFF_DEPTH.
- ready[v] = (count != BUFF_DEPTH).
- valid_out[v] = (count != 0); data_out[v] = head slot, read from a register.
- Latency: a flit pushed in cycle t appears at valid_out in cycle t+1. There is no bypass.
- Simultaneous push and pop while full: both happen; count is unchanged.
- Simultaneous push and pop while empty: push only; the pop is suppressed by POP_CHECK_VALID.

Per-VC buffer, BUFF_DEPTH == 1:
- Full-throughput single-slot elastic buffer.
- When full, ready is high whenever the downstream pops in the same cycle.

Per-VC buffer, BUFF_DEPTH == 0:
- data_out[v] = data_in; valid_out[v] = push[v]; ready[v] = ready_in[v].
- err_overflow is never set.

Pop:
- pop[v] = valid_out[v] & ready_in[v] when POP_CHECK_VALID, else ready_in[v].

back_notify:
- Credit mode, REG_CR_UPD = 0: back_notify[v] = pop[v].
- Credit mode, REG_CR_UPD = 1: back_notify[v] = pop[v] delayed by one cycle.
- Each pop produces exactly one single-cycle pulse; pops on different VCs in the same cycle pulse independently.
- Elastic mode: back_notify[v] = ready[v].

Errors:
- Overflow (credit mode only): a push to a VC that is full with no pop in the same cycle drops the flit and sets err_overflow.
- Bad VC: valid_in with vc_in >= NUM_VCS drops the flit, sets err_bad_vc, and produces no credit.
- Both flags clear only on rst.

Decomposition:
- Shared package axi4_duth_noc_pkg: reuse flow_control_type.
- Add to the package: a link_fc_params_rcv_vc_type struct (FC_TYPE, BUFF_DEPTH, NUM_VCS, REG_CR_UPD, POP_CHECK_VALID) and preset constants RTR_VC2_CREDITS_3_FC_RCV and NI_VC2_ELASTIC_2_FC_RCV.
- One sub-module, rcv_vc_buffer: a single-VC buffer that selects the depth-0 / 1 / >1 implementation internally (reusing eb_one_slot and fifo_duth) and exports push, ready, valid, pop and data.
- The top level instantiates rcv_vc_buffer once per VC in a generate loop, plus the demux, the credit registers and the error flags.

Test Plan:
1. Credit mode, NUM_VCS=2, DEPTH=3, REG_CR_UPD=1, ready_in=00: push 0xA1, 0xA2, 0xA3 on VC1. Expect valid_out=10 from the cycle after the first push and data_out[1]=0xA1. Raise ready_in[1]: pops 0xA1..0xA3 on consecutive cycles, back_notify[1] pulses 3 cycles, each one cycle after its pop.
2. Credit mode, VC0 full (3 flits), ready_in=00: push a 4th flit. Expect err_overflow=1, count stays 3, the 4th flit is never output. Repeat with a full VC and pop/push in the same cycle: no error, FIFO order preserved.
3. Elastic mode, DEPTH=2: fill VC0. Expect back_notify[0]=0 while back_notify[1]=1; VC1 traffic continues unblocked (no head-of-line blocking).
4. NUM_VCS=3: valid_in with vc_in=3. Expect err_bad_vc=1, no valid_out change, no credit.
5. Pointer wrap, DEPTH=3: stream 10 flits 0x00..0x09 with ready_in toggling 1010... Expect in-order output and total credit pulses = 10.
6. Mid-stream reset: rst asserted with 2 flits buffered. Next cycle: valid_out=0, back_notify=0, no credits for dropped flits; a new flit after reset returns data 0x55 with correct latency.
